lsu_mem_if: RTL and testbench
=============================

// Module: lsu_mem_if
// PURPOSE
//  Load/store unit: executes the memory access requested by the decoder's MemRW/LoadType/LoadSigned controls.
//  Drives a req/gnt/rvalid data-memory port and generates byte enables and store-lane replication.
//  Aligns and extends load data for the WBSel=00 writeback path.
//  Stalls the core until the access completes; sits between the execute stage and the data memory.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles in REQ+WAIT before abort with o_err (1..65535)
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst_n        in   1   asynchronous active-low reset
//  i_req_vld      in   1   load/store present in execute (held by core while o_stall)
//  i_mem_rw       in   1   1=store, 0=load
//  i_load_type    in   4   size mask: 0001 byte, 0011 half, 1111 word; other values illegal
//  i_load_signed  in   1   1=sign-extend load, 0=zero-extend
//  i_addr         in   32  byte address (ALU result)
//  i_wdata        in   32  store data (rs2)
//  o_stall        out  1   freeze PC/pipeline
//  o_done         out  1   1-cycle completion pulse
//  o_err          out  1   valid with o_done: misaligned, illegal size or timeout
//  o_rdata        out  32  extended load data, valid with o_done, held until next load completes
//  o_mem_req      out  1   memory request
//  o_mem_we       out  1   write enable, qualified by o_mem_req
//  o_mem_addr     out  32  word address {addr[31:2],2'b00}
//  o_mem_be       out  4   byte enables
//  o_mem_wdata    out  32  lane-replicated store data
//  i_mem_gnt      in   1   request accepted this cycle
//  i_mem_rvalid   in   1   read data valid (same cycle as gnt or later)
//  i_mem_rdata    in   32  read word
// BEHAVIOUR
//  Reset (async on i_rst_n low): state=IDLE, timeout counter=0; all outputs and capture registers 0.
//  FSM IDLE->REQ->(WAIT)->DONE->IDLE:
//   IDLE: on i_req_vld, latch rw/type/signed/addr/wdata.
//    Illegal size, half with addr[0]=1, or word with addr[1:0]!=0 -> DONE with err=1, no memory request.
//    Otherwise -> REQ.
//   REQ: o_mem_req=1 with stable addr/we/be/wdata until i_mem_gnt.
//    On gnt: store -> DONE; load with i_mem_rvalid same cycle -> DONE; load otherwise -> WAIT.
//   WAIT: o_mem_req=0; on i_mem_rvalid capture data -> DONE. rvalid outside WAIT/REQ-gnt is ignored.
//   DONE: o_done=1 for 1 cycle; no new request accepted; -> IDLE.
//  o_stall = i_req_vld & ~o_done (combinational). The core advances on the edge ending the DONE cycle.
//  The new instruction is accepted in the following IDLE cycle.
//  Latency: zero-wait memory gives stall of 2 cycles and o_done in the 3rd cycle after i_req_vld.
//  Byte enables: o_mem_be = i_load_type << addr[1:0] (4-bit truncated; always legal after the align check).
//  Store data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
//  Load data: sh = i_mem_rdata >> (8*addr[1:0]); byte -> ext(sh[7:0]); half -> ext(sh[15:0]); word -> rdata.
//   Sign/zero extension is selected by the latched LoadSigned. o_rdata updates only on a successful load.
//  Error paths: o_rdata is cleared to 0 and o_err=1 for the o_done cycle.
//   o_err on a store means the memory was not written (misalign) or is unknown (timeout).
//  Timeout: counter clears on entering REQ and increments each REQ/WAIT cycle.
//   When the counter reaches TIMEOUT_CYC: -> DONE with err=1, o_mem_req drops.
//   Late gnt/rvalid after the abort is ignored.
//  i_req_vld dropping mid-access (flush): the access still runs to DONE, because memory may be committed.
//   The o_done pulse is still produced; o_stall follows i_req_vld.
//  Simultaneous gnt+rvalid in REQ for a load: a single-cycle hand-off; WAIT is skipped.
//  Reset mid-access: immediate return to IDLE, o_mem_req=0 asynchronously; the outstanding access is abandoned.
// TESTING
//  Zero-wait SW addr=0x100 wdata=0xDEADBEEF, gnt in REQ:
//   -> be=1111, addr=0x100, wdata=0xDEADBEEF, o_done at cycle 3, stall 2 cycles.
//  SB addr=0x103 wdata=0x000000A5 -> be=1000, o_mem_wdata=0xA5A5A5A5, o_mem_addr=0x100.
//  LB addr=0x102 rdata=0x12805634 (gnt cycle, rvalid 3 cycles later) -> o_rdata=0xFFFFFF80.
//   LBU on the same data -> 0x00000080; LHU addr=0x102 -> 0x00001280.
//  LH addr=0x101 -> no o_mem_req, o_done+o_err next cycle, o_rdata=0.
//   LoadType=0111 -> same error response.
//  Load with gnt never asserted, TIMEOUT_CYC=8 -> o_mem_req high 8 cycles, then o_done+o_err.
//   A gnt arriving afterwards -> no effect.
//  i_rst_n low during WAIT -> o_mem_req/o_done/o_stall paths idle immediately.
//   A following LW completes normally.

Source files
------------

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - load/store unit driving a req/gnt/rvalid data-memory port
module lsu_mem_if #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_vld,
    input  logic        i_mem_rw,
    input  logic [3:0]  i_load_type,
    input  logic        i_load_signed,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_type;
    logic        r_signed;
    logic [1:0]  r_off;

    logic        w_size_ok;
    logic        w_align_ok;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [15:0] w_shift;
    logic [31:0] w_load_ext;
    logic        w_timeout;

    always_comb begin
        w_size_ok = (i_load_type == 4'b0001) || (i_load_type == 4'b0011) ||
                    (i_load_type == 4'b1111);
        case (i_load_type)
            4'b0011: w_align_ok = ~i_addr[0];
            4'b1111: w_align_ok = (i_addr[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
        case (i_load_type)
            4'b0001: w_wdata = {4{i_wdata[7:0]}};
            4'b0011: w_wdata = {2{i_wdata[15:0]}};
            default: w_wdata = i_wdata;
        endcase
    end

    assign w_be      = i_load_type << i_addr[1:0];
    assign w_shift   = 16'(i_mem_rdata >> {r_off, 3'b000});
    assign w_timeout = (r_cnt == LP_TO_LAST);
    assign o_stall   = i_req_vld & ~o_done;

    // Extension uses the request's latched size/sign, not the live decoder controls.
    always_comb begin
        case (r_type)
            4'b0001: w_load_ext = {{24{r_signed & w_shift[7]}}, w_shift[7:0]};
            4'b0011: w_load_ext = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
            default: w_load_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_type      <= 4'd0;
            r_signed    <= 1'b0;
            r_off       <= 2'd0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_rdata     <= 32'd0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_be    <= 4'd0;
            o_mem_wdata <= 32'd0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_vld) begin
                        r_type      <= i_load_type;
                        r_signed    <= i_load_signed;
                        r_off       <= i_addr[1:0];
                        o_mem_we    <= i_mem_rw;
                        o_mem_addr  <= {i_addr[31:2], 2'b00};
                        o_mem_be    <= w_be;
                        o_mem_wdata <= w_wdata;
                        if (!w_size_ok || !w_align_ok) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                            o_err   <= 1'b1;
                            o_rdata <= 32'd0;
                        end else begin
                            r_state   <= S_REQ;
                            o_mem_req <= 1'b1;
                            r_cnt     <= 16'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (i_mem_gnt) begin
                        o_mem_req <= 1'b0;
                        if (o_mem_we || i_mem_rvalid) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                            if (!o_mem_we) o_rdata <= w_load_ext;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= r_cnt + 16'd1;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        o_mem_req <= 1'b0;
                        o_done    <= 1'b1;
                        o_err     <= 1'b1;
                        o_rdata   <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        r_state <= S_DONE;
                        o_done  <= 1'b1;
                        o_rdata <= w_load_ext;
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                        o_done  <= 1'b1;
                        o_err   <= 1'b1;
                        o_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb/tb_lsu_mem_if.sv - scoreboard bench for lsu_mem_if
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld, mem_rw, load_signed;
    logic [3:0]  load_type;
    logic [31:0] addr, wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_if #(.TIMEOUT_CYC(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld), .i_mem_rw(mem_rw),
        .i_load_type(load_type), .i_load_signed(load_signed), .i_addr(addr),
        .i_wdata(wdata), .o_stall(stall), .o_done(done), .o_err(err), .o_rdata(rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
        .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid),
        .i_mem_rdata(mem_rdata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                chk("sb_depth", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_err", 32'(err), 32'(e.err));
                chk("sb_rdata", rdata, e.rdata);
            end
        end
    end

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] off,
                                             input logic [3:0] t, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        if (t == 4'b0001) return sgn ? {{24{b[7]}}, b} : {24'd0, b};
        if (t == 4'b0011) return sgn ? {{16{h[15]}}, h} : {16'd0, h};
        return w;
    endfunction

    // Drives one access, plays the memory side, checks request fields and timing.
    task automatic access(input string tag, input logic rw, input logic [3:0] t,
                          input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] mrd, input int gnt_dly, input int rv_dly,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input int exp_req_cyc, input int exp_done_cyc, input bit flush);
        exp_t e;
        int cyc = 1, req_cyc = 0, stall_cyc = 0, since = 0, done_cyc = 0;
        bit first = 1, gnt_given = 0, rv_given = 0, seen_done = 0;
        e.err = exp_err;
        e.rdata = exp_rd;
        sb_q.push_back(e);
        @(negedge clk);
        req_vld = 1'b1; mem_rw = rw; load_type = t; load_signed = sgn;
        addr = a; wdata = wd; mem_rdata = mrd;
        #1;
        while (!seen_done && cyc < 200) begin
            if (stall) stall_cyc++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (mem_req) begin
                if (first) begin
                    chk({tag, "_be"}, 32'(mem_be), 32'(exp_be));
                    chk({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
                    chk({tag, "_we"}, 32'(mem_we), 32'(rw));
                    if (rw) chk({tag, "_wdata"}, mem_wdata, exp_wd);
                    first = 0;
                end
                if (!gnt_given && req_cyc == gnt_dly) begin
                    mem_gnt = 1'b1;
                    gnt_given = 1;
                    if (!rw && rv_dly == 0) begin
                        mem_rvalid = 1'b1;
                        rv_given = 1;
                    end
                end
                req_cyc++;
            end else if (gnt_given && !rw && !rv_given) begin
                since++;
                if (since == rv_dly) begin
                    mem_rvalid = 1'b1;
                    rv_given = 1;
                end
            end
            if (done) begin
                seen_done = 1;
                done_cyc = cyc;
            end
            if (flush) req_vld = 1'b0;
            #1;
        end
        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        if (exp_req_cyc >= 0) chk({tag, "_req_cycles"}, 32'(req_cyc), 32'(exp_req_cyc));
        if (exp_done_cyc > 0) begin
            chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
            chk({tag, "_stall_cycles"}, 32'(stall_cyc), flush ? 32'd1 : 32'(exp_done_cyc - 1));
        end
        @(negedge clk);
        req_vld = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_last;
        rst_n = 1'b0; req_vld = 1'b0; mem_rw = 1'b0; load_type = 4'b0; load_signed = 1'b0;
        addr = 32'd0; wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        rst_n = 1'b1;

        access("sw", 1, 4'b1111, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 32'd0,
               4'b1111, 32'hDEADBEEF, 1, 3, 0);
        access("sb", 1, 4'b0001, 0, 32'h103, 32'h000000A5, 0, 0, 0, 0, 32'd0,
               4'b1000, 32'hA5A5A5A5, 1, 3, 0);
        access("lb", 0, 4'b0001, 1, 32'h102, 0, 32'h12805634, 0, 3, 0, 32'hFFFFFF80,
               4'b0100, 0, 1, 6, 0);
        access("lbu", 0, 4'b0001, 0, 32'h102, 0, 32'h12805634, 1, 0, 0, 32'h00000080,
               4'b0100, 0, 2, 4, 0);
        access("lhu", 0, 4'b0011, 0, 32'h102, 0, 32'h12805634, 0, 1, 0, 32'h00001280,
               4'b1100, 0, 1, 4, 0);
        access("sh", 1, 4'b0011, 0, 32'h102, 32'h1234ABCD, 0, 2, 0, 0, 32'h00001280,
               4'b1100, 32'hABCDABCD, 3, 5, 0);
        access("lh_mis", 0, 4'b0011, 1, 32'h101, 0, 0, 0, 0, 1, 32'd0, 0, 0, 0, 2, 0);
        access("lw", 0, 4'b1111, 0, 32'h200, 0, 32'hCAFEF00D, 0, 0, 0, 32'hCAFEF00D,
               4'b1111, 0, 1, 3, 0);
        access("ill_sz", 0, 4'b0111, 0, 32'h100, 0, 0, 0, 0, 1, 32'd0, 0, 0, 0, 2, 0);
        access("lw_mis", 0, 4'b1111, 0, 32'h202, 0, 0, 0, 0, 1, 32'd0, 0, 0, 0, 2, 0);
        access("tmo", 0, 4'b1111, 0, 32'h300, 0, 0, 1000, 0, 1, 32'd0, 4'b1111, 0, 8, 10, 0);

        repeat (3) begin
            mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
            @(posedge clk);
            @(negedge clk);
            chk("late_gnt_done", 32'(done), 32'd0);
            chk("late_gnt_req", 32'(mem_req), 32'd0);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("late_gnt_rdata", rdata, 32'd0);

        access("flush", 0, 4'b1111, 0, 32'h400, 0, 32'h55AA33CC, 1, 2, 0, 32'h55AA33CC,
               4'b1111, 0, 2, 6, 1);

        for (int i = 0; i < 12; i++) begin
            logic [3:0]  t;
            logic [1:0]  off;
            logic [31:0] d;
            logic        s;
            int          k;
            k = int'($urandom_range(0, 2));
            t = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0011 : 4'b1111;
            off = 2'($urandom_range(0, 3));
            if (k == 1) off[0] = 1'b0;
            if (k == 2) off = 2'b00;
            d = $urandom;
            s = 1'($urandom_range(0, 1));
            exp_last = ld_model(d, off, t, s);
            access("rnd_ld", 0, t, s, {20'h00600, 10'($urandom_range(0, 1023)), off}, 0, d,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, exp_last,
                   4'(t << off), 0, -1, -1, 0);
        end

        // Reset while the request is still being presented.
        @(negedge clk);
        req_vld = 1'b1; mem_rw = 1'b0; load_type = 4'b1111; addr = 32'h500;
        repeat (2) @(negedge clk);
        chk("rst_req_pre", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_req_async", 32'(mem_req), 32'd0);
        req_vld = 1'b0;
        #1 chk("rst_req_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while waiting for read data.
        @(negedge clk);
        req_vld = 1'b1; addr = 32'h504;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("wait_req_low", 32'(mem_req), 32'd0);
        #2 rst_n = 1'b0; req_vld = 1'b0;
        #1 chk("rst_wait_req", 32'(mem_req), 32'd0);
        chk("rst_wait_done", 32'(done), 32'd0);
        chk("rst_wait_stall", 32'(stall), 32'd0);
        chk("rst_wait_rdata", rdata, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rst_wait_ignored", 32'(done), 32'd0);
        rst_n = 1'b1;

        access("lw_post", 0, 4'b1111, 0, 32'h600, 0, 32'h0BADC0DE, 0, 0, 0, 32'h0BADC0DE,
               4'b1111, 0, 1, 3, 0);

        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
